byte_bus_arbiter: RTL
=====================

// Module: byte_bus_arbiter
// PURPOSE
//   Shares the 8-bit byte-serial external bus between two 32-bit requesters
//   (req0 = instruction fetch, req1 = data port) and sequences each transfer.
//   A transfer is: address/write-data bytes LSB first, then a control byte,
//   then read-data bytes for reads. Sits between the CPU ports and the
//   uo_out/uio_* pads, replacing a free-running phase counter with a
//   request-driven FSM.
// PARAMETERS
//   NBYTES      4  bytes per word; address and data widths are 8*NBYTES
//   TURN_CYCLES 1  idle cycles between CTRL and the first read byte (>=0)
// PORTS
//   clk       in   1         system clock, all flops on posedge
//   rst_n     in   1         async active-low reset
//   req0      in   1         requester 0 wants the bus; hold high until done0
//   rw0       in   1         1 = read, 0 = write
//   addr0     in   8*NBYTES  requester 0 address
//   wdata0    in   8*NBYTES  requester 0 write data
//   gnt0      out  1         high while requester 0 owns the bus
//   done0     out  1         one-cycle pulse: requester 0 transfer complete
//   req1/rw1/addr1/wdata1/gnt1/done1   same as above for requester 1
//   rdata     out  8*NBYTES  read data; valid in the done cycle of a read
//   bus_out   out  8         address / control byte to pads (uo_out)
//   bus_dout  out  8         write-data byte to pads (uio_out)
//   bus_din   in   8         read-data byte from pads (uio_in)
//   bus_oe    out  8         pad output enable, 8'hFF drive / 8'h00 input
//   bus_sync  out  1         high in the first ADDR cycle of each frame
// BEHAVIOUR
//   Reset (async, rst_n=0): state IDLE; gnt*, done*, bus_out, bus_dout,
//     bus_oe, bus_sync = 0; rdata = 0; byte index = 0; last_owner = 1.
//     Reset mid-transfer aborts it: no done pulse, bus released.
//   FSM: IDLE -> ADDR -> CTRL -> [TURN] -> [RDATA] -> DONE -> IDLE.
//   IDLE: if any req, pick owner, latch its rw/addr/wdata, set gnt, go ADDR.
//     Both req: owner = requester != last_owner (round-robin).
//   ADDR (NBYTES cycles, idx 0..NBYTES-1): bus_out = addr byte idx,
//     bus_dout = wdata byte idx if write else 0, bus_oe = 8'hFF if write
//     else 8'h00; bus_sync = 1 only at idx 0.
//   CTRL (1 cycle): bus_out = {1'b1, 6'b0, ~rw}, bus_dout = 0, bus_oe = 0.
//     Write -> DONE. Read -> TURN if TURN_CYCLES>0, else RDATA.
//   TURN (TURN_CYCLES cycles): bus_out = 0, bus_oe = 0.
//   RDATA (NBYTES cycles): rdata byte idx <= bus_din at posedge; idx wraps 0.
//   DONE (1 cycle): done<owner> = 1, gnt still 1; last_owner <= owner;
//     next cycle gnt = 0 and state IDLE. A new grant is made no earlier
//     than the cycle after DONE.
//   Latency, grant cycle to done pulse: write 1+NBYTES+1;
//     read 1+NBYTES+1+TURN_CYCLES+NBYTES (defaults: 6 and 11 cycles).
//   req dropped mid-transfer is ignored: the latched transfer completes.
//   addr/wdata/rw changed after grant have no effect (latched copy used).
//   rdata holds its value across writes and idle; only RDATA updates it.
//   gnt0 and gnt1 are never high together.
// CONFIGURATION
//   ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie; last_owner
//     is unused (kept at its reset value). Not defined: round-robin as above.
// TESTING
//   1 write: req0=1,rw0=0,addr0=32'h1234_5678,wdata0=32'hAABB_CCDD ->
//     bus_out 78,56,34,12 with bus_dout DD,CC,BB,AA, oe FF; CTRL 8'h81;
//     done0 6 cycles after grant.
//   2 read: req1=1,rw1=1,addr1=32'h0000_0010, bus_din 11,22,33,44 in RDATA
//     -> CTRL 8'h80, oe 00 throughout, rdata=32'h4433_2211 at done1.
//   3 tie: req0=req1=1 from reset, held -> grants 0,1,0,1 alternate
//     (with ARB_FIXED_PRIO_EN: 0,0,0 while req0 held).
//   4 reset mid-RDATA: rst_n low at idx 2 -> gnt/oe/bus_out 0 at once,
//     no done; next req gets a full fresh frame with bus_sync=1.
//   5 req0 dropped during ADDR -> transfer still completes, done0 pulses once.
//   6 TURN_CYCLES=0 read -> RDATA immediately after CTRL; done 10 cycles
//     after grant.

Source files
------------

// File: rtl/byte_bus_arbiter.sv
// byte_bus_arbiter: shares the 8-bit byte-serial bus between two word requesters and sequences each frame
//   Frame: ADDR (address + write-data bytes, LSB first), CTRL, [TURN], [RDATA], DONE.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     req*/rw*/addr*/wdata*           requester 0 (fetch) and 1 (data) request side
//     gnt*/done*                      ownership flag and one-cycle completion pulse
//     rdata                           assembled read word, valid in the DONE cycle of a read
//     bus_out/bus_dout/bus_din        address+control byte out, write byte out, read byte in
//     bus_oe/bus_sync                 pad output enable, first-ADDR-cycle marker
//   Build option: define ARB_FIXED_PRIO_EN to make requester 0 win every tie
//     (round-robin otherwise).
module byte_bus_arbiter #(
   parameter int NBYTES      = 4,
   parameter int TURN_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req0,
   input  logic                  rw0,
   input  logic [8*NBYTES-1:0]   addr0,
   input  logic [8*NBYTES-1:0]   wdata0,
   output logic                  gnt0,
   output logic                  done0,
   input  logic                  req1,
   input  logic                  rw1,
   input  logic [8*NBYTES-1:0]   addr1,
   input  logic [8*NBYTES-1:0]   wdata1,
   output logic                  gnt1,
   output logic                  done1,
   output logic [8*NBYTES-1:0]   rdata,
   output logic [7:0]            bus_out,
   output logic [7:0]            bus_dout,
   input  logic [7:0]            bus_din,
   output logic [7:0]            bus_oe,
   output logic                  bus_sync
);
   localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
   localparam int TW = TURN_CYCLES > 1 ? $clog2(TURN_CYCLES) : 1;
   localparam logic [BW-1:0] LAST  = BW'(NBYTES - 1);
   localparam logic [TW-1:0] TLAST = TW'(TURN_CYCLES > 0 ? TURN_CYCLES - 1 : 0);
   typedef enum logic [2:0] {IDLE, ADDR, CTRL, TURN, RDATA, DONE} state_t;
   state_t state;
   logic owner, last_owner, rw_q, pick, sel_rw;
   logic [NBYTES-1:0][7:0] addr_q, wdata_q, rd_q, sel_addr, sel_wdata;
   logic [BW-1:0] idx, nidx;
   logic [TW-1:0] tcnt;
`ifdef ARB_FIXED_PRIO_EN
   assign pick = ~req0;
`else
   // pick = 1 selects requester 1; on a tie the one that did not go last wins
   assign pick = (req0 & req1) ? ~last_owner : req1;
`endif
   assign sel_rw    = pick ? rw1 : rw0;
   assign sel_addr  = pick ? addr1 : addr0;
   assign sel_wdata = pick ? wdata1 : wdata0;
   assign nidx      = idx + 1'b1;
   assign rdata     = rd_q;
   // Outputs are registered: each transition loads the bus values of the state being entered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         rw_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         idx        <= '0;
         tcnt       <= '0;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         done0      <= 1'b0;
         done1      <= 1'b0;
         bus_out    <= 8'h00;
         bus_dout   <= 8'h00;
         bus_oe     <= 8'h00;
         bus_sync   <= 1'b0;
      end else begin
         done0    <= 1'b0;
         done1    <= 1'b0;
         bus_sync <= 1'b0;
         case (state)
            IDLE: if (req0 | req1) begin
               owner    <= pick;
               rw_q     <= sel_rw;
               addr_q   <= sel_addr;
               wdata_q  <= sel_wdata;
               gnt0     <= ~pick;
               gnt1     <= pick;
               idx      <= '0;
               state    <= ADDR;
               bus_out  <= sel_addr[0];
               bus_dout <= sel_rw ? 8'h00 : sel_wdata[0];
               bus_oe   <= sel_rw ? 8'h00 : 8'hFF;
               bus_sync <= 1'b1;
            end
            ADDR: if (idx == LAST) begin
               idx      <= '0;
               state    <= CTRL;
               bus_out  <= {1'b1, 6'b0, ~rw_q};
               bus_dout <= 8'h00;
               bus_oe   <= 8'h00;
            end else begin
               idx      <= nidx;
               bus_out  <= addr_q[nidx];
               bus_dout <= rw_q ? 8'h00 : wdata_q[nidx];
            end
            CTRL: begin
               bus_out <= 8'h00;
               tcnt    <= '0;
               if (!rw_q) begin
                  state <= DONE;
                  done0 <= ~owner;
                  done1 <= owner;
               end else
                  state <= (TURN_CYCLES > 0) ? TURN : RDATA;
            end
            TURN: if (tcnt == TLAST) state <= RDATA; else tcnt <= tcnt + 1'b1;
            RDATA: begin
               rd_q[idx] <= bus_din;
               idx       <= (idx == LAST) ? '0 : nidx;
               if (idx == LAST) begin
                  state <= DONE;
                  done0 <= ~owner;
                  done1 <= owner;
               end
            end
            DONE: begin
               gnt0  <= 1'b0;
               gnt1  <= 1'b0;
               state <= IDLE;
`ifndef ARB_FIXED_PRIO_EN
               last_owner <= owner;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
